calc_entry_fsm: RTL
===================

CALC_ENTRY_FSM -- requirements
Module: calc_entry_fsm

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000: inactivity limit in clk cycles; used only when CALC_ENTRY_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single rising-edge clock.
REQ-003 clear_n  input  1  reset, synchronous, active-low.
REQ-004 key_valid  input  1  one-cycle strobe; key_code is valid while it is high.
REQ-005 key_code  input  5  0-15 hex digit; 16 PLUS; 17 MINUS; 18 EQUALS; 19 CANCEL; 20-31 invalid.
REQ-006 num1  output  4  first operand issued downstream.
REQ-007 num2  output  4  second operand issued downstream.
REQ-008 op_selected  output  1  0 add, 1 subtract.
REQ-009 operands_valid  output  1  one-cycle pulse; num1/num2/op_selected changed this cycle.
REQ-010 err  output  1  one-cycle pulse on rejected key.
REQ-011 timeout  output  1  one-cycle pulse on inactivity abort.
REQ-012 state  output  2  current state encoding (debug).

Function
REQ-013 States: S_NUM1=0 (wait first digit), S_OP=1 (wait operator), S_NUM2=2 (wait second digit), S_EQ=3 (wait EQUALS).
REQ-014 Each key_valid cycle is processed in that cycle; state, shadow registers and pulses update at that clk edge; no backpressure.
REQ-015 S_NUM1: digit -> shadow_a=digit, go S_OP; any other valid code -> err, stay.
REQ-016 S_OP: digit -> overwrite shadow_a, stay; PLUS/MINUS -> shadow_op=0/1, go S_NUM2; EQUALS -> err, stay.
REQ-017 S_NUM2: digit -> shadow_b=digit, go S_EQ; PLUS/MINUS -> overwrite shadow_op, stay; EQUALS -> err, stay.
REQ-018 S_EQ: digit -> overwrite shadow_b, stay; PLUS/MINUS -> err, stay; EQUALS -> num1=shadow_a, num2=shadow_b, op_selected=shadow_op, operands_valid=1, go S_NUM1.
REQ-019 Issue latency: operands_valid and new outputs register at the edge sampling EQUALS, visible one cycle later for exactly one cycle.
REQ-020 num1, num2, op_selected change only on issue; they hold between issues, including during entry, CANCEL and timeout.
REQ-021 CANCEL in any state: go S_NUM1, clear shadow registers to 0, no err, outputs unchanged.
REQ-022 Codes 20-31 in any state: err pulse, no state or register change.
REQ-023 err, operands_valid, timeout never assert together; none asserts without cause.
REQ-024 Keys with key_valid low are ignored entirely.

Reset
REQ-025 clear_n low at a clk edge: state=S_NUM1, shadows=0, num1=0, num2=0, op_selected=0, all pulses 0, timeout counter 0.
REQ-026 Reset mid-entry discards partial entry; reset has priority over any simultaneous key.

Configuration
REQ-027 Macro CALC_ENTRY_TIMEOUT_EN defined: counter clears on every key_valid and while in S_NUM1, else increments; on reaching TIMEOUT_CYCLES-1 next edge -> S_NUM1, shadows cleared, timeout pulse.
REQ-028 Key_valid in the expiring cycle wins: key processed normally, counter cleared, no timeout.
REQ-029 Macro undefined: no counter instantiated, timeout tied 0, entry waits indefinitely.

Verification
REQ-030 Reset, then keys 5, PLUS, 3, EQUALS -> one operands_valid pulse, num1=5, num2=3, op_selected=0.
REQ-031 Keys 9, 2 (overwrite), MINUS, PLUS, MINUS, 15, EQUALS -> num1=2, num2=15, op_selected=1.
REQ-032 Keys 4, PLUS, CANCEL, EQUALS -> no operands_valid, err on EQUALS, state=S_NUM1, outputs hold prior values.
REQ-033 Key PLUS in S_NUM1 and code 25 in S_OP -> err pulse each, state unchanged.
REQ-034 Macro defined, TIMEOUT_CYCLES=8: key 7 then idle -> timeout pulse after 8 cycles, state=S_NUM1; key on 8th cycle -> no timeout.
REQ-035 clear_n low during S_EQ with EQUALS same cycle -> no operands_valid, all outputs 0.

Source files
------------

// File: rtl/calc_entry_fsm.sv
`default_nettype none
// ============================================================================
// Module      : calc_entry_fsm
// Description : Keypad entry sequencer for a two-operand add/subtract unit.
//               Collects digit, operator, digit, EQUALS and issues the
//               operands downstream as a one-cycle operands_valid pulse.
//               Optional inactivity abort enabled by CALC_ENTRY_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_entry_fsm #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       key_valid,
    input  logic [4:0] key_code,
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic       op_selected,
    output logic       operands_valid,
    output logic       err,
    output logic       timeout,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_NUM1 = 2'd0,
        S_OP   = 2'd1,
        S_NUM2 = 2'd2,
        S_EQ   = 2'd3
    } state_t;

    localparam logic [4:0] C_PLUS   = 5'd16;
    localparam logic [4:0] C_MINUS  = 5'd17;
    localparam logic [4:0] C_EQUALS = 5'd18;
    localparam logic [4:0] C_CANCEL = 5'd19;

    state_t     state_q, state_d;
    logic [3:0] shadow_a_q, shadow_a_d;
    logic [3:0] shadow_b_q, shadow_b_d;
    logic       shadow_op_q, shadow_op_d;
    logic [3:0] num1_q, num1_d;
    logic [3:0] num2_q, num2_d;
    logic       op_q, op_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;
    logic       timeout_q, timeout_d;

    logic       is_digit_w;
    logic       is_oper_w;
    logic       is_invalid_w;
    logic       expire_w;

    assign is_digit_w   = ~key_code[4];
    assign is_oper_w    = (key_code == C_PLUS) || (key_code == C_MINUS);
    assign is_invalid_w = (key_code > C_CANCEL);

`ifdef CALC_ENTRY_TIMEOUT_EN
    localparam int         CW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Expiry fires only on an idle cycle; a key arriving in that cycle wins.
    assign expire_w = ~key_valid && (state_q != S_NUM1) && (cnt_q == C_LAST);

    // Inactivity counter: restarts on any key or while waiting for a first digit.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (key_valid || (state_q == S_NUM1) || expire_w) begin
            cnt_d = '0;
        end
    end

    // Inactivity counter register.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic [31:0] unused_timeout_cycles_w;
    assign unused_timeout_cycles_w = TIMEOUT_CYCLES;
    assign expire_w                = 1'b0;
`endif

    // Next-state, shadow-register and pulse decode for one key per cycle.
    always_comb begin
        state_d     = state_q;
        shadow_a_d  = shadow_a_q;
        shadow_b_d  = shadow_b_q;
        shadow_op_d = shadow_op_q;
        num1_d      = num1_q;
        num2_d      = num2_q;
        op_d        = op_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        timeout_d   = 1'b0;

        if (key_valid) begin
            if (key_code == C_CANCEL) begin
                state_d     = S_NUM1;
                shadow_a_d  = 4'd0;
                shadow_b_d  = 4'd0;
                shadow_op_d = 1'b0;
            end else if (is_invalid_w) begin
                err_d = 1'b1;
            end else begin
                case (state_q)
                    S_NUM1: begin
                        if (is_digit_w) begin
                            shadow_a_d = key_code[3:0];
                            state_d    = S_OP;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    S_OP: begin
                        if (is_digit_w) begin
                            shadow_a_d = key_code[3:0];
                        end else if (is_oper_w) begin
                            shadow_op_d = key_code[0];
                            state_d     = S_NUM2;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    S_NUM2: begin
                        if (is_digit_w) begin
                            shadow_b_d = key_code[3:0];
                            state_d    = S_EQ;
                        end else if (is_oper_w) begin
                            shadow_op_d = key_code[0];
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    default: begin // S_EQ
                        if (is_digit_w) begin
                            shadow_b_d = key_code[3:0];
                        end else if (key_code == C_EQUALS) begin
                            num1_d  = shadow_a_q;
                            num2_d  = shadow_b_q;
                            op_d    = shadow_op_q;
                            valid_d = 1'b1;
                            state_d = S_NUM1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                endcase
            end
        end else if (expire_w) begin
            state_d     = S_NUM1;
            shadow_a_d  = 4'd0;
            shadow_b_d  = 4'd0;
            shadow_op_d = 1'b0;
            timeout_d   = 1'b1;
        end
    end

    // State, shadow, output and pulse registers; reset overrides any key.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q     <= S_NUM1;
            shadow_a_q  <= 4'd0;
            shadow_b_q  <= 4'd0;
            shadow_op_q <= 1'b0;
            num1_q      <= 4'd0;
            num2_q      <= 4'd0;
            op_q        <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_a_q  <= shadow_a_d;
            shadow_b_q  <= shadow_b_d;
            shadow_op_q <= shadow_op_d;
            num1_q      <= num1_d;
            num2_q      <= num2_d;
            op_q        <= op_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            timeout_q   <= timeout_d;
        end
    end

    assign num1           = num1_q;
    assign num2           = num2_q;
    assign op_selected    = op_q;
    assign operands_valid = valid_q;
    assign err            = err_q;
    assign timeout        = timeout_q;
    assign state          = state_q;

endmodule
`default_nettype wire
